maq_ms_tick: RTL and testbench
==============================

Name: maq_ms_tick

Overview:
Seconds/minutes time base and set controller for the 24 h clock. Divides maqh_clock to a 1 Hz enable and counts seconds (00-59) and minutes (00-59) in BCD. Drives enable_1hz/inc_m/inc_h, which the hours counter uses as its increment interface. The hours counter advances only in a cycle where all three are high. Also provides push-button time setting through a small mode FSM.

Parameters:
CLK_HZ, 50000000, maqh_clock frequency; divider terminal count = CLK_HZ-1 (sims use 4)
SYNC_STAGES, 2, flop stages in each button synchronizer (>=2)

Ports:
maqh_clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
btn_mode  input  1  async mode button, active-high
btn_up  input  1  async increment button, active-high
enable_1hz  output  1  one-cycle advance pulse to hours counter
inc_m  output  1  minute-carry qualifier to hours counter
inc_h  output  1  hour-carry qualifier to hours counter
maqs_lsd  output  4  seconds units, BCD 0-9
maqs_msd  output  3  seconds tens, 0-5
maqm_lsd  output  4  minutes units, BCD 0-9
maqm_msd  output  3  minutes tens, 0-5
mode  output  2  00 RUN, 01 SET_H, 10 SET_M (11 unused)

Behaviour:
- Reset: already decided, reset is asynchronous, active-low; clock is maqh_clock. Reset clears the divider, all digits, synchronizers and edge registers, and sets mode=RUN. Outputs during reset: enable_1hz=0, inc_m=0, inc_h=0, all digits 0. Reset mid-operation aborts immediately. No pulse is emitted on release.
- Buttons: each passes through a SYNC_STAGES synchronizer, then a rising-edge detect (sync & ~sync_d). This gives one-cycle up_ev/mode_ev. A held button produces exactly one event. There is no debounce; upstream handles it.
- FSM: RUN -> SET_H -> SET_M -> RUN, advancing on mode_ev. The 11 encoding recovers to RUN on the next clock.
- Simultaneous mode_ev and up_ev: the mode change wins and up_ev is dropped.
- RUN, divider: counts 0..CLK_HZ-1 and wraps. Its terminal count sets the registered enable_1hz to 1 for exactly the next cycle. Period is CLK_HZ cycles; the first pulse comes CLK_HZ cycles after reset release.
- RUN, seconds/minutes: update only on edges where enable_1hz=1.
  - Seconds: lsd 9 -> 0 with msd+1; 59 -> 00.
  - Minutes advance only when seconds=59; 59 -> 00.
- RUN, carry outputs (combinational from current registered digits, so they show pre-increment values at the sampling edge):
  - inc_m = (seconds==59)
  - inc_h = (minutes==59)
- SET_H:
  - Divider held at 0; seconds and minutes frozen.
  - up_ev produces a one-cycle pulse with enable_1hz=inc_m=inc_h=1 in the following cycle. This advances hours by exactly one (23 -> 00 handled by the hours counter).
  - Otherwise all three outputs are 0.
- SET_M:
  - Divider held at 0; seconds frozen.
  - up_ev increments minutes mod 60 with no hour carry.
  - enable_1hz, inc_m and inc_h are held at 0.
- SET_M -> RUN transition: seconds and divider cleared to 0. Minutes and hours are kept.
- Glitch rule: in every state, enable_1hz never stays high more than one cycle. inc_m/inc_h may be high without enable_1hz, which does not advance hours.
- Digits never leave their legal ranges: lsd 0-9, msd 0-5.

Test Plan:
- Reset and tick: CLK_HZ=4, release reset, run 12 cycles -> enable_1hz high in cycle 4, 8, 12 (one cycle each); seconds reach 03; mode=00.
- Minute roll: preload via 59 ticks to seconds=59, minutes=00 -> inc_m=1, inc_h=0 at the pulse; next state seconds=00, minutes=01; hours unchanged.
- Hour carry: run to minutes=59, seconds=59 -> at the enable_1hz edge inc_m=inc_h=1; next state 00:00 (min:sec), and a connected hours counter goes 00 -> 01.
- Set hours: press btn_mode once (mode=01), then pulse btn_up three times with separated presses -> exactly three enable_1hz&inc_m&inc_h pulses; hours 00 -> 03; seconds frozen; holding btn_up 50 cycles gives one pulse.
- Set minutes and exit: mode=10, minutes=58, two btn_up presses -> minutes=00, no enable_1hz; press btn_mode -> mode=00, seconds=00, first enable_1hz CLK_HZ cycles later.
- Simultaneous press and async reset: btn_mode and btn_up rise together in RUN -> mode=01, no hour pulse. Assert reset mid-count at seconds=37 -> all outputs 0 and mode=00 asynchronously; no pulse on release.

Source files
------------

// File: rtl/maq_ms_tick.sv
// Seconds/minutes BCD time base with 1 Hz divider and push-button set FSM.
// Drives the hours counter through the enable_1hz/inc_m/inc_h qualifier triple.
module maq_ms_tick #(
    parameter int CLK_HZ      = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       maqh_clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       enable_1hz,
    output logic       inc_m,
    output logic       inc_h,
    output logic [3:0] maqs_lsd,
    output logic [2:0] maqs_msd,
    output logic [3:0] maqm_lsd,
    output logic [2:0] maqm_msd,
    output logic [1:0] mode
);
    localparam int            DW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DIV_TC = DW'(CLK_HZ - 1);

    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_SETH = 2'b01;
    localparam logic [1:0] S_SETM = 2'b10;

    logic [SYNC_STAGES-1:0] r_mode_sync, r_up_sync;
    logic                   r_mode_d, r_up_d;
    logic [1:0]             r_state;
    logic [DW-1:0]          r_div;
    logic                   r_en;
    logic [3:0]             r_s_lsd, r_m_lsd;
    logic [2:0]             r_s_msd, r_m_msd;

    logic       w_mode_ev, w_up_ev;
    logic       w_run, w_seth, w_setm;
    logic       w_sec59, w_min59;
    logic [3:0] w_s_lsd_n, w_m_lsd_n;
    logic [2:0] w_s_msd_n, w_m_msd_n;

    // A mode press in the same cycle as an up press swallows the up press.
    assign w_mode_ev = r_mode_sync[SYNC_STAGES-1] & ~r_mode_d;
    assign w_up_ev   = r_up_sync[SYNC_STAGES-1] & ~r_up_d & ~w_mode_ev;

    assign w_run  = (r_state == S_RUN);
    assign w_seth = (r_state == S_SETH);
    assign w_setm = (r_state == S_SETM);

    assign w_sec59 = (r_s_msd == 3'd5) && (r_s_lsd == 4'd9);
    assign w_min59 = (r_m_msd == 3'd5) && (r_m_lsd == 4'd9);

    assign w_s_lsd_n = (r_s_lsd == 4'd9) ? 4'd0 : r_s_lsd + 4'd1;
    assign w_s_msd_n = (r_s_lsd != 4'd9) ? r_s_msd : (r_s_msd == 3'd5) ? 3'd0 : r_s_msd + 3'd1;
    assign w_m_lsd_n = (r_m_lsd == 4'd9) ? 4'd0 : r_m_lsd + 4'd1;
    assign w_m_msd_n = (r_m_lsd != 4'd9) ? r_m_msd : (r_m_msd == 3'd5) ? 3'd0 : r_m_msd + 3'd1;

    always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
            r_mode_sync <= '0;
            r_up_sync   <= '0;
            r_mode_d    <= 1'b0;
            r_up_d      <= 1'b0;
        end else begin
            r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], btn_mode};
            r_up_sync   <= {r_up_sync[SYNC_STAGES-2:0], btn_up};
            r_mode_d    <= r_mode_sync[SYNC_STAGES-1];
            r_up_d      <= r_up_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN:   r_state <= w_mode_ev ? S_SETH : S_RUN;
                S_SETH:  r_state <= w_mode_ev ? S_SETM : S_SETH;
                S_SETM:  r_state <= w_mode_ev ? S_RUN  : S_SETM;
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Divider only runs in RUN, so leaving SET_M restarts a full second.
    always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_en  <= 1'b0;
        end else begin
            r_div <= (w_run && r_div != DIV_TC) ? r_div + 1'b1 : '0;
            r_en  <= (w_run && !w_mode_ev && r_div == DIV_TC) || (w_seth && w_up_ev);
        end
    end

    always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
            r_s_lsd <= '0;
            r_s_msd <= '0;
            r_m_lsd <= '0;
            r_m_msd <= '0;
        end else if (w_run && r_en) begin
            r_s_lsd <= w_s_lsd_n;
            r_s_msd <= w_s_msd_n;
            if (w_sec59) begin
                r_m_lsd <= w_m_lsd_n;
                r_m_msd <= w_m_msd_n;
            end
        end else if (w_setm) begin
            if (w_up_ev) begin
                r_m_lsd <= w_m_lsd_n;
                r_m_msd <= w_m_msd_n;
            end
            if (w_mode_ev) begin
                r_s_lsd <= '0;
                r_s_msd <= '0;
            end
        end
    end

    // In SET_H the registered pulse doubles as both carry qualifiers.
    assign enable_1hz = r_en;
    assign inc_m      = (w_run && w_sec59) || (w_seth && r_en);
    assign inc_h      = (w_run && w_min59) || (w_seth && r_en);
    assign maqs_lsd   = r_s_lsd;
    assign maqs_msd   = r_s_msd;
    assign maqm_lsd   = r_m_lsd;
    assign maqm_msd   = r_m_msd;
    assign mode       = r_state;
endmodule

// File: tb/tb_maq_ms_tick.sv
// Bench for maq_ms_tick: time-of-hour model compared every cycle plus directed scenarios.
module tb_maq_ms_tick;
    localparam int CLK_HZ = 4;
    localparam int SS     = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_up = 1'b0;
    logic       enable_1hz, inc_m, inc_h;
    logic [3:0] maqs_lsd, maqm_lsd;
    logic [2:0] maqs_msd, maqm_msd;
    logic [1:0] mode;

    int npass = 0, ntot = 0;

    maq_ms_tick #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(SS)) dut (
        .maqh_clock(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
        .enable_1hz(enable_1hz), .inc_m(inc_m), .inc_h(inc_h),
        .maqs_lsd(maqs_lsd), .maqs_msd(maqs_msd), .maqm_lsd(maqm_lsd), .maqm_msd(maqm_msd),
        .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    endtask

    // Model: seconds-of-hour t, divider phase, mode, and the pending advance pulse.
    int       t = 0, ph = 0, mmode = 0, mhrs = 0, dhrs = 0;
    bit       men = 0;
    bit [SS:0] hm = '0, hu = '0;

    function automatic bit exp_incm();
        return (mmode == 0) ? (t % 60 == 59) : (mmode == 1 && men);
    endfunction
    function automatic bit exp_inch();
        return (mmode == 0) ? (t / 60 == 59) : (mmode == 1 && men);
    endfunction

    always @(posedge clk or negedge reset) begin
        int nt, nph, nmode;
        bit nen, mev, uev;
        if (!reset) begin
            t <= 0; ph <= 0; mmode <= 0; men <= 0; mhrs <= 0; hm <= '0; hu <= '0;
        end else begin
            mev = hm[SS-1] & ~hm[SS];
            uev = hu[SS-1] & ~hu[SS];
            nt = t; nph = 0; nen = 0;
            if (men && exp_incm() && exp_inch()) mhrs <= (mhrs + 1) % 24;
            case (mmode)
                0: begin
                    if (men) nt = (t + 1) % 3600;
                    nen = !mev && (ph == CLK_HZ - 1);
                    nph = (ph + 1) % CLK_HZ;
                end
                1: nen = uev && !mev;
                default: begin
                    if (uev && !mev) nt = ((t / 60 + 1) % 60) * 60 + t % 60;
                    if (mev) nt = nt - nt % 60;
                end
            endcase
            nmode = mev ? (mmode + 1) % 3 : mmode;
            t <= nt; ph <= nph; men <= nen; mmode <= nmode;
            hm <= {hm[SS-1:0], btn_mode};
            hu <= {hu[SS-1:0], btn_up};
        end
    end

    // Hours counter attached to the DUT's qualifier outputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) dhrs <= 0;
        else if (enable_1hz && inc_m && inc_h) dhrs <= (dhrs + 1) % 24;
    end

    always @(negedge clk) begin
        chk("m_en",    enable_1hz, men);
        chk("m_incm",  inc_m, exp_incm());
        chk("m_inch",  inc_h, exp_inch());
        chk("m_slsd",  maqs_lsd, (t % 60) % 10);
        chk("m_smsd",  maqs_msd, (t % 60) / 10);
        chk("m_mlsd",  maqm_lsd, (t / 60) % 10);
        chk("m_mmsd",  maqm_msd, (t / 60) / 10);
        chk("m_mode",  mode, mmode);
        chk("m_hours", dhrs, mhrs);
    end

    task automatic press(input bit is_mode, input int hold);
        @(negedge clk);
        if (is_mode) btn_mode = 1'b1; else btn_up = 1'b1;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int i;
        logic [6:0] s0;
        repeat (3) @(negedge clk);
        chk("rst_en", enable_1hz, 0);
        chk("rst_mode", mode, 0);
        chk("rst_digits", {maqs_msd, maqs_lsd, maqm_msd, maqm_lsd}, 0);
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("tick_en", enable_1hz, (k % 4 == 0));
        end
        chk("tick_sec12", maqs_lsd, 2);
        @(negedge clk);
        chk("tick_sec13", maqs_lsd, 3);
        chk("tick_mode", mode, 0);

        // Minute roll
        for (i = 0; i < 400 && !(maqs_msd == 5 && maqs_lsd == 9 && enable_1hz); i++) @(negedge clk);
        chk("roll_found", enable_1hz, 1);
        chk("roll_incm", inc_m, 1);
        chk("roll_inch", inc_h, 0);
        @(negedge clk);
        chk("roll_sec", {maqs_msd, maqs_lsd}, 0);
        chk("roll_min", {maqm_msd, maqm_lsd}, 1);
        chk("roll_hrs", dhrs, 0);

        // Hour carry at 59:59
        for (i = 0; i < 16000 && !(maqm_msd == 5 && maqm_lsd == 9 && maqs_msd == 5 && maqs_lsd == 9 && enable_1hz); i++)
            @(negedge clk);
        chk("hc_found", enable_1hz, 1);
        chk("hc_incm", inc_m, 1);
        chk("hc_inch", inc_h, 1);
        @(negedge clk);
        chk("hc_digits", {maqm_msd, maqm_lsd, maqs_msd, maqs_lsd}, 0);
        chk("hc_hrs", dhrs, 1);

        // Set hours
        press(1, 3);
        chk("seth_mode", mode, 1);
        s0 = {maqs_msd, maqs_lsd};
        repeat (3) press(0, 2);
        chk("seth_hrs3", dhrs, 4);
        press(0, 50);
        chk("seth_hold", dhrs, 5);
        chk("seth_frozen", {maqs_msd, maqs_lsd}, s0);

        // Set minutes and exit
        press(1, 3);
        chk("setm_mode", mode, 2);
        repeat (58) press(0, 2);
        chk("setm_58", {maqm_msd, maqm_lsd}, {3'd5, 4'd8});
        repeat (2) press(0, 2);
        chk("setm_wrap", {maqm_msd, maqm_lsd}, 0);
        chk("setm_hrs", dhrs, 5);
        @(negedge clk);
        btn_mode = 1'b1;
        for (i = 0; i < 10 && mode != 0; i++) @(negedge clk);
        chk("exit_mode", mode, 0);
        chk("exit_sec", {maqs_msd, maqs_lsd}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("exit_first_en", enable_1hz, (k == 4));
        end
        btn_mode = 1'b0;
        repeat (4) @(negedge clk);

        // Simultaneous mode and up
        btn_mode = 1'b1; btn_up = 1'b1;
        repeat (4) @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0;
        repeat (6) @(negedge clk);
        chk("simul_mode", mode, 1);
        chk("simul_hrs", dhrs, 5);
        press(1, 3);
        press(1, 3);
        chk("back_run", mode, 0);

        // Async reset mid-count
        for (i = 0; i < 400 && !(maqs_msd == 3 && maqs_lsd == 7); i++) @(negedge clk);
        chk("rst37_found", {maqs_msd, maqs_lsd}, {3'd3, 4'd7});
        #2 reset = 1'b0;
        #1;
        chk("arst_outs", {enable_1hz, inc_m, inc_h, maqs_msd, maqs_lsd, maqm_msd, maqm_lsd, mode}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("release_en", enable_1hz, 0);
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
